// File: rtl/alu64_arbiter.sv
// alu64_arbiter: two requesters share a single 64-bit ALU through a
// round-robin arbiter and a three-state IDLE/EXEC/DONE sequencer.
// Optional feature macro: ALU_ARB_ERRCHK_EN. When it is defined, control
// codes outside the legal set return resp_err=1 with a zero result and
// zero flags. When it is undefined, every code is passed to the ALU as-is.

// Shared ALU: ainvert=control[3], binvert=control[2], op=control[1:0]
// (00 AND, 01 OR, 10 ADD, 11 set-less-than). Carry and overflow are only
// reported for the add path.
module alu64 #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             ainvert_i,
    input  logic             binvert_i,
    input  logic [1:0]       op_i,
    output logic [WIDTH-1:0] result_o,
    output logic             cout_o,
    output logic             zero_o,
    output logic             overflow_o
);
    logic [WIDTH-1:0] a_m;
    logic [WIDTH-1:0] b_m;
    logic [WIDTH:0]   sum;
    logic             sum_ovf;

    // Operand inversion, adder with carry-in = binvert, result select
    always_comb begin
        a_m        = ainvert_i ? ~a_i : a_i;
        b_m        = binvert_i ? ~b_i : b_i;
        sum        = {1'b0, a_m} + {1'b0, b_m} + {{WIDTH{1'b0}}, binvert_i};
        sum_ovf    = (a_m[WIDTH-1] == b_m[WIDTH-1]) && (sum[WIDTH-1] != a_m[WIDTH-1]);
        result_o   = '0;
        cout_o     = 1'b0;
        overflow_o = 1'b0;
        case (op_i)
            2'b00: result_o = a_m & b_m;
            2'b01: result_o = a_m | b_m;
            2'b10: begin
                result_o   = sum[WIDTH-1:0];
                cout_o     = sum[WIDTH];
                overflow_o = sum_ovf;
            end
            default: result_o = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ sum_ovf};
        endcase
        zero_o = (result_o == '0);
    end
endmodule

module alu64_arbiter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_control,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_control,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_cout,
    output logic             resp_zero,
    output logic             resp_overflow,
    output logic             resp_err
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;     // requester granted most recently
    logic             grant;              // requester that wins this IDLE cycle
    logic             accept;
    logic [WIDTH-1:0] a_q, b_q;
    logic [3:0]       ctrl_q;
    logic             id_q;
    logic [WIDTH-1:0] result_q;
    logic             cout_q, zero_q, ovf_q;
    logic [WIDTH-1:0] alu_result;
    logic             alu_cout, alu_zero, alu_ovf;

`ifdef ALU_ARB_ERRCHK_EN
    logic             err_q;

    function automatic logic is_legal(input logic [3:0] c);
        case (c)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b1101: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction
`endif

    alu64 #(.WIDTH(WIDTH)) u_alu (
        .a_i        (a_q),
        .b_i        (b_q),
        .ainvert_i  (ctrl_q[3]),
        .binvert_i  (ctrl_q[2]),
        .op_i       (ctrl_q[1:0]),
        .result_o   (alu_result),
        .cout_o     (alu_cout),
        .zero_o     (alu_zero),
        .overflow_o (alu_ovf)
    );

    // Grant, readies and next state; the grant is recomputed every IDLE cycle
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        grant      = (req0_valid && req1_valid) ? ~last_q : req1_valid;
        case (state_q)
            IDLE: begin
                req0_ready = !reset && req0_valid && !grant;
                req1_ready = !reset && req1_valid && grant;
                accept     = req0_ready || req1_ready;
                if (accept) begin
                    state_d = EXEC;
                    last_d  = grant;
                end
            end
            EXEC: state_d = DONE;
            DONE: if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and round-robin pointer; requester 0 wins the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Capture the granted requester's operation on acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            id_q <= 1'b0;
        end else if (accept) begin
            id_q   <= grant;
            a_q    <= grant ? req1_a : req0_a;
            b_q    <= grant ? req1_b : req0_b;
            ctrl_q <= grant ? req1_control : req0_control;
        end
    end

    // Register the ALU outcome during EXEC; held stable through DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef ALU_ARB_ERRCHK_EN
            err_q    <= 1'b0;
`endif
        end else if (state_q == EXEC) begin
`ifdef ALU_ARB_ERRCHK_EN
            if (!is_legal(ctrl_q)) begin
                result_q <= '0;
                cout_q   <= 1'b0;
                zero_q   <= 1'b0;
                ovf_q    <= 1'b0;
                err_q    <= 1'b1;
            end else begin
                result_q <= alu_result;
                cout_q   <= alu_cout;
                zero_q   <= alu_zero;
                ovf_q    <= alu_ovf;
                err_q    <= 1'b0;
            end
`else
            result_q <= alu_result;
            cout_q   <= alu_cout;
            zero_q   <= alu_zero;
            ovf_q    <= alu_ovf;
`endif
        end
    end

    assign resp_valid    = (state_q == DONE);
    assign resp_id       = id_q;
    assign resp_result   = result_q;
    assign resp_cout     = cout_q;
    assign resp_zero     = zero_q;
    assign resp_overflow = ovf_q;
`ifdef ALU_ARB_ERRCHK_EN
    assign resp_err      = err_q;
`else
    assign resp_err      = 1'b0;
`endif
endmodule

// File: tb/tb_alu64_arbiter.sv
// Self-checking bench for alu64_arbiter: reset state, a table of directed
// operations, round-robin, backpressure, reset abort, illegal code and
// randomized operations against a behavioural model.
module tb_alu64_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_control, req1_control;
    logic        resp_valid, resp_ready, resp_id;
    logic [63:0] resp_result;
    logic        resp_cout, resp_zero, resp_overflow, resp_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [63:0] result;
        logic        cout;
        logic        zero;
        logic        ovf;
        logic        err;
        logic        id;
    } res_t;

    typedef struct {
        logic        id;
        logic [3:0]  c;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] result;
        logic        cout;
        logic        zero;
        logic        ovf;
    } vec_t;

    always #5 clk = ~clk;

    alu64_arbiter #(.WIDTH(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_a        (req0_a),
        .req0_b        (req0_b),
        .req0_control  (req0_control),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_a        (req1_a),
        .req1_b        (req1_b),
        .req1_control  (req1_control),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_id       (resp_id),
        .resp_result   (resp_result),
        .resp_cout     (resp_cout),
        .resp_zero     (resp_zero),
        .resp_overflow (resp_overflow),
        .resp_err      (resp_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference behaviour computed from the operation definitions
    function automatic res_t model(input logic id, input logic [3:0] c,
                                   input logic [63:0] a, input logic [63:0] b);
        res_t        r;
        logic [64:0] s;
        r    = '0;
        r.id = id;
        case (c)
            4'b0000: r.result = a & b;
            4'b0001: r.result = a | b;
            4'b0010: begin
                s        = {1'b0, a} + {1'b0, b};
                r.result = s[63:0];
                r.cout   = s[64];
                r.ovf    = (a[63] == b[63]) && (r.result[63] != a[63]);
            end
            4'b0110: begin
                r.result = a - b;
                r.cout   = (a >= b);
                r.ovf    = (a[63] != b[63]) && (r.result[63] != a[63]);
            end
            4'b1100: r.result = ~(a | b);
            4'b1101: r.result = ~(a & b);
            default: begin
`ifdef ALU_ARB_ERRCHK_EN
                r.err    = 1'b1;
                r.result = '0;
`else
                r.result = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
`endif
            end
        endcase
        r.zero = (r.result == 64'd0) && !r.err;
        return r;
    endfunction

    task automatic cmp_res(input string tag, input res_t got, input res_t exp);
        chk({tag, ".result"}, got.result, exp.result);
        chk({tag, ".cout"},   {63'd0, got.cout}, {63'd0, exp.cout});
        chk({tag, ".zero"},   {63'd0, got.zero}, {63'd0, exp.zero});
        chk({tag, ".ovf"},    {63'd0, got.ovf},  {63'd0, exp.ovf});
        chk({tag, ".err"},    {63'd0, got.err},  {63'd0, exp.err});
        chk({tag, ".id"},     {63'd0, got.id},   {63'd0, exp.id});
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic drive(input logic id, input logic [3:0] c,
                         input logic [63:0] a, input logic [63:0] b);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_control = c;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_control = c;
        end
    endtask

    // One full operation from a single requester; returns the response fields.
    // The handshake cycle starts at edge N, the accepting edge is N+1 and the
    // response is visible after edge N+2.
    task automatic run_op(input string tag, input logic id, input logic [3:0] c,
                          input logic [63:0] a, input logic [63:0] b, output res_t r);
        int n;
        r = '0;
        drive(id, c, a, b);
        n = 0;
        @(negedge clk);
        while (!(id ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            chk({tag, ".accept_timeout"}, 64'd0, 64'd1);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        chk({tag, ".lat_exec"}, {63'd0, resp_valid}, 64'd0);
        @(negedge clk);
        chk({tag, ".lat_done"}, {63'd0, resp_valid}, 64'd1);
        r.result = resp_result;
        r.cout   = resp_cout;
        r.zero   = resp_zero;
        r.ovf    = resp_overflow;
        r.err    = resp_err;
        r.id     = resp_id;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    vec_t vt[9];
    res_t r, e, held;
    int   acc_cyc[$];
    logic acc_id[$];
    int   overlap, bad;
    logic [3:0] legal_codes[6];

    initial begin
        vt[0] = '{1'b0, 4'b0000, 64'hffffffffffffffff, 64'h3, 64'h0000000000000003, 1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b1, 4'b0010, 64'hffffffffffffffff, 64'h8000000000000000, 64'h7fffffffffffffff, 1'b1, 1'b0, 1'b1};
        vt[2] = '{1'b0, 4'b0110, 64'h0123456789abcdef, 64'h0123456789abcdef, 64'h0, 1'b1, 1'b1, 1'b0};
        vt[3] = '{1'b1, 4'b0001, 64'hf0f0f0f0f0f0f0f0, 64'h0f0f0f0f0f0f0f0f, 64'hffffffffffffffff, 1'b0, 1'b0, 1'b0};
        vt[4] = '{1'b0, 4'b1100, 64'h0, 64'h0, 64'hffffffffffffffff, 1'b0, 1'b0, 1'b0};
        vt[5] = '{1'b1, 4'b1101, 64'hffffffffffffffff, 64'hffffffffffffffff, 64'h0, 1'b0, 1'b1, 1'b0};
        vt[6] = '{1'b0, 4'b0110, 64'h0, 64'h1, 64'hffffffffffffffff, 1'b0, 1'b0, 1'b0};
        vt[7] = '{1'b1, 4'b0010, 64'h7fffffffffffffff, 64'h1, 64'h8000000000000000, 1'b0, 1'b0, 1'b1};
        vt[8] = '{1'b0, 4'b0110, 64'h8000000000000000, 64'h1, 64'h7fffffffffffffff, 1'b1, 1'b0, 1'b1};
        legal_codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b1101};

        req0_a = '0; req0_b = '0; req0_control = '0;
        req1_a = '0; req1_b = '0; req1_control = '0;

        // Reset state, with both requesters pushing during reset
        reset = 1'b1; resp_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst.ready0", {63'd0, req0_ready}, 64'd0);
        chk("rst.ready1", {63'd0, req1_ready}, 64'd0);
        chk("rst.resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst.resp_fields", {resp_result}, 64'd0);
        chk("rst.resp_flags", {59'd0, resp_id, resp_cout, resp_zero, resp_overflow, resp_err}, 64'd0);
        do_reset();

        // Grant follows the current valids when a requester withdraws
        @(posedge clk); #1;
        drive(1'b1, 4'b0000, 64'h0, 64'h0);
        @(negedge clk);
        chk("withdraw.ready1", {62'd0, req1_ready, req0_ready}, 64'd2);
        req1_valid = 1'b0;
        drive(1'b0, 4'b0001, 64'h0, 64'h0);
        #1;
        chk("withdraw.ready0", {62'd0, req1_ready, req0_ready}, 64'd1);
        req0_valid = 1'b0;
        @(posedge clk); #1;

        // Directed table
        do_reset();
        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), vt[i].id, vt[i].c, vt[i].a, vt[i].b, r);
            e        = '0;
            e.result = vt[i].result;
            e.cout   = vt[i].cout;
            e.zero   = vt[i].zero;
            e.ovf    = vt[i].ovf;
            e.id     = vt[i].id;
            cmp_res($sformatf("vec%0d", i), r, e);
        end

        // Round robin with both requesters always valid
        do_reset();
        drive(1'b0, 4'b0010, 64'h1, 64'h2);
        drive(1'b1, 4'b0001, 64'h4, 64'h8);
        resp_ready = 1'b1;
        overlap = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge clk);
            if (req0_ready && req1_ready) overlap++;
            if (req0_ready) begin acc_id.push_back(1'b0); acc_cyc.push_back(cyc); end
            else if (req1_ready) begin acc_id.push_back(1'b1); acc_cyc.push_back(cyc); end
        end
        chk("rr.overlap", 64'(overlap), 64'd0);
        chk("rr.count", 64'(acc_id.size()), 64'd5);
        for (int k = 0; k < acc_id.size(); k++) begin
            chk($sformatf("rr.id%0d", k), {63'd0, acc_id[k]}, 64'(k % 2));
            if (k > 0) chk($sformatf("rr.gap%0d", k), 64'(acc_cyc[k] - acc_cyc[k-1]), 64'd3);
        end

        // Backpressure in DONE: response held, nothing accepted
        do_reset();
        drive(1'b0, 4'b0010, 64'h10, 64'h20);
        @(negedge clk);
        chk("stall.ready0", {63'd0, req0_ready}, 64'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        drive(1'b1, 4'b0001, 64'h3, 64'h5);
        @(negedge clk);
        @(negedge clk);
        chk("stall.valid", {63'd0, resp_valid}, 64'd1);
        held = model(1'b0, 4'b0010, 64'h10, 64'h20);
        chk("stall.result", resp_result, held.result);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (!resp_valid || resp_result !== held.result || resp_id !== 1'b0 ||
                req0_ready || req1_ready) bad++;
        end
        chk("stall.hold", 64'(bad), 64'd0);
        resp_ready = 1'b1;
        #1;
        chk("stall.hs_ready1", {63'd0, req1_ready}, 64'd0);
        @(posedge clk); #1 resp_ready = 1'b0;
        @(negedge clk);
        chk("stall.after_valid", {63'd0, resp_valid}, 64'd0);
        chk("stall.after_ready1", {63'd0, req1_ready}, 64'd1);
        @(posedge clk); #1 req1_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("stall.next_valid", {63'd0, resp_valid}, 64'd1);
        chk("stall.next_id", {63'd0, resp_id}, 64'd1);
        chk("stall.next_result", resp_result, 64'h7);
        resp_ready = 1'b1;
        @(posedge clk); #1 resp_ready = 1'b0;

        // Reset during EXEC discards the operation
        do_reset();
        drive(1'b0, 4'b0010, 64'h1, 64'h1);
        @(negedge clk);
        chk("rstexec.ready0", {63'd0, req0_ready}, 64'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) bad++;
        end
        chk("rstexec.no_resp", 64'(bad), 64'd0);
        chk("rstexec.result", resp_result, 64'd0);

        // Code 0111: error response with the checker, raw ALU output without
        @(posedge clk); #1;
        run_op("illegal", 1'b1, 4'b0111, 64'h5, 64'h9, r);
        cmp_res("illegal", r, model(1'b1, 4'b0111, 64'h5, 64'h9));

        // Randomized single-requester operations against the model
        for (int t = 0; t < 40; t++) begin
            logic        id;
            logic [3:0]  c;
            logic [63:0] a, b;
            id = 1'($urandom_range(0, 1));
            c  = legal_codes[$urandom_range(0, 5)];
`ifdef ALU_ARB_ERRCHK_EN
            if ($urandom_range(0, 4) == 0) c = 4'($urandom);
`endif
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: b = a;
                1: a = 64'hffffffffffffffff;
                2: b = 64'h8000000000000000;
                3: a = 64'h0;
                default: ;
            endcase
            run_op($sformatf("rnd%0d", t), id, c, a, b, r);
            cmp_res($sformatf("rnd%0d", t), r, model(id, c, a, b));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
